// File: rtl/sdram_burst_sched.sv
// Burst scheduler for sdram_ctrl: arbitrates write-FIFO drain and read-FIFO fill bursts
// round-robin, keeping circular write/read address pointers within their regions.
module sdram_burst_sched #(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 10,
    parameter int LVL_W      = 11,
    parameter int FIFO_DEPTH = 1024,
    parameter int TIMEOUT    = 4095
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              sdram_init_end_i,
    input  logic [LVL_W-1:0]  wr_fifo_level_i,
    input  logic [LVL_W-1:0]  rd_fifo_level_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] wr_base_i,
    input  logic [ADDR_W-1:0] wr_end_i,
    input  logic [ADDR_W-1:0] rd_base_i,
    input  logic [ADDR_W-1:0] rd_end_i,
    input  logic [LEN_W-1:0]  wr_burst_len_i,
    input  logic [LEN_W-1:0]  rd_burst_len_i,
    input  logic              addr_reset_i,
    output logic              sdram_wr_req_o,
    output logic [ADDR_W-1:0] sdram_wr_addr_o,
    output logic [LEN_W-1:0]  sdram_wr_length_o,
    input  logic              sdram_wr_ack_i,
    output logic              sdram_rd_req_o,
    output logic [ADDR_W-1:0] sdram_rd_addr_o,
    output logic [LEN_W-1:0]  sdram_rd_length_o,
    input  logic              sdram_rd_ack_i,
    output logic              busy_o,
    output logic              wr_wrap_o,
    output logic              rd_wrap_o,
    output logic              err_o
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W:0] DEPTH = (LVL_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;
    state_t state, state_nxt;

    logic              wr_elig, rd_elig, grant_wr, grant_rd;
    logic              last_rd, addr_pend, to_idle, reload;
    logic              wr_done, rd_done, req_timeout;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   wr_next, rd_next;
    logic [TMR_W-1:0]  tmr;

    // Extra bit on the level comparisons so level+len cannot overflow.
    assign wr_elig = sdram_init_end_i && (wr_burst_len_i != '0) &&
                     ({1'b0, wr_fifo_level_i} >= (LVL_W+1)'(wr_burst_len_i));
    assign rd_elig = sdram_init_end_i && rd_en_i && (rd_burst_len_i != '0) &&
                     (({1'b0, rd_fifo_level_i} + (LVL_W+1)'(rd_burst_len_i)) <= DEPTH);
    assign grant_wr = (state == IDLE) && wr_elig && (!rd_elig || last_rd);
    assign grant_rd = (state == IDLE) && rd_elig && (!wr_elig || !last_rd);

    assign req_timeout = (tmr == TMR_W'(TIMEOUT - 1));
    assign wr_done     = (state == WR_BURST) && !sdram_wr_ack_i;
    assign rd_done     = (state == RD_BURST) && !sdram_rd_ack_i;
    assign wr_next     = {1'b0, wr_ptr} + (ADDR_W+1)'(sdram_wr_length_o);
    assign rd_next     = {1'b0, rd_ptr} + (ADDR_W+1)'(sdram_rd_length_o);
    assign to_idle     = (state != IDLE) && (state_nxt == IDLE);
    assign reload      = ((state == IDLE) && addr_reset_i) ||
                         (to_idle && (addr_pend || addr_reset_i));

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_wr)      state_nxt = WR_REQ;
                else if (grant_rd) state_nxt = RD_REQ;
            end
            WR_REQ: begin
                if (sdram_wr_req_o) begin
                    if (sdram_wr_ack_i)   state_nxt = WR_BURST;
                    else if (req_timeout) state_nxt = IDLE;
                end
            end
            WR_BURST: if (!sdram_wr_ack_i) state_nxt = IDLE;
            RD_REQ: begin
                if (sdram_rd_req_o) begin
                    if (sdram_rd_ack_i)   state_nxt = RD_BURST;
                    else if (req_timeout) state_nxt = IDLE;
                end
            end
            RD_BURST: if (!sdram_rd_ack_i) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
    end

    // Request stays up only while the FSM remains in its REQ state, so ack or timeout drop it.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            sdram_wr_req_o <= 1'b0;
            sdram_rd_req_o <= 1'b0;
            wr_wrap_o      <= 1'b0;
            rd_wrap_o      <= 1'b0;
            err_o          <= 1'b0;
            last_rd        <= 1'b1;
            addr_pend      <= 1'b0;
            tmr            <= '0;
            wr_ptr         <= wr_base_i;
            rd_ptr         <= rd_base_i;
        end else begin
            sdram_wr_req_o <= (state == WR_REQ) && (state_nxt == WR_REQ);
            sdram_rd_req_o <= (state == RD_REQ) && (state_nxt == RD_REQ);
            wr_wrap_o      <= 1'b0;
            rd_wrap_o      <= 1'b0;
            addr_pend      <= (state != IDLE) && !to_idle && (addr_pend || addr_reset_i);
            if (to_idle && ((state == WR_REQ) || (state == RD_REQ))) err_o <= 1'b1;
            if (grant_wr)      last_rd <= 1'b0;
            else if (grant_rd) last_rd <= 1'b1;
            if (state == IDLE)
                tmr <= '0;
            else if (((state == WR_REQ) && sdram_wr_req_o) || ((state == RD_REQ) && sdram_rd_req_o))
                tmr <= tmr + TMR_W'(1);
            if (reload) begin
                wr_ptr <= wr_base_i;
                rd_ptr <= rd_base_i;
            end else begin
                if (wr_done) begin
                    if (wr_next >= {1'b0, wr_end_i}) begin
                        wr_ptr    <= wr_base_i;
                        wr_wrap_o <= 1'b1;
                    end else begin
                        wr_ptr <= wr_next[ADDR_W-1:0];
                    end
                end
                if (rd_done) begin
                    if (rd_next >= {1'b0, rd_end_i}) begin
                        rd_ptr    <= rd_base_i;
                        rd_wrap_o <= 1'b1;
                    end else begin
                        rd_ptr <= rd_next[ADDR_W-1:0];
                    end
                end
            end
        end
    end

    // Burst descriptor captured at grant; an IDLE-cycle address reload takes priority.
    always_ff @(posedge sys_clk_i) begin
        if (grant_wr) begin
            sdram_wr_addr_o   <= addr_reset_i ? wr_base_i : wr_ptr;
            sdram_wr_length_o <= wr_burst_len_i;
        end
        if (grant_rd) begin
            sdram_rd_addr_o   <= addr_reset_i ? rd_base_i : rd_ptr;
            sdram_rd_length_o <= rd_burst_len_i;
        end
    end
endmodule

// File: tb/tb_sdram_burst_sched.sv
// Scoreboard bench for sdram_burst_sched: expected bursts are queued by the stimulus,
// a negedge monitor pops and compares each request as it rises.
module tb_sdram_burst_sched;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;
    localparam int LVL_W  = 11;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst, init_end, rd_en, addr_reset;
    logic [LVL_W-1:0]  wr_lvl, rd_lvl;
    logic [ADDR_W-1:0] wr_base, wr_end, rd_base, rd_end;
    logic [LEN_W-1:0]  wr_len, rd_len;
    logic              wr_req, rd_req, wr_ack, rd_ack;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [LEN_W-1:0]  wr_length, rd_length;
    logic              busy, wr_wrap, rd_wrap, err;

    always #5 clk = ~clk;

    sdram_burst_sched #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LVL_W(LVL_W), .FIFO_DEPTH(1024), .TIMEOUT(TMO)
    ) dut (
        .sys_clk_i(clk), .rst_i(rst), .sdram_init_end_i(init_end),
        .wr_fifo_level_i(wr_lvl), .rd_fifo_level_i(rd_lvl), .rd_en_i(rd_en),
        .wr_base_i(wr_base), .wr_end_i(wr_end), .rd_base_i(rd_base), .rd_end_i(rd_end),
        .wr_burst_len_i(wr_len), .rd_burst_len_i(rd_len), .addr_reset_i(addr_reset),
        .sdram_wr_req_o(wr_req), .sdram_wr_addr_o(wr_addr), .sdram_wr_length_o(wr_length),
        .sdram_wr_ack_i(wr_ack),
        .sdram_rd_req_o(rd_req), .sdram_rd_addr_o(rd_addr), .sdram_rd_length_o(rd_length),
        .sdram_rd_ack_i(rd_ack),
        .busy_o(busy), .wr_wrap_o(wr_wrap), .rd_wrap_o(rd_wrap), .err_o(err)
    );

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } burst_t;

    burst_t exp_q[$];
    burst_t mon_e;
    int     checks = 0, errors = 0, burst_cnt = 0, wr_wraps = 0, rd_wraps = 0;
    bit     wr_noack = 1'b0;
    logic   wp = 1'b0, rp = 1'b0;
    bit     saw_idle = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        burst_t b;
        b.is_wr = w;
        b.addr  = a;
        b.len   = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_bursts(input int target, input string name);
        int n = 0;
        while (burst_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(burst_cnt >= target), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || wr_req || rd_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 0);
    endtask

    // Monitor: every rising request is matched against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!busy) saw_idle = 1'b1;
            if (wr_wrap) wr_wraps++;
            if (rd_wrap) rd_wraps++;
            if ((wr_req && !wp) || (rd_req && !rp)) begin
                chk("req_overlap", 32'(wr_req & rd_req), 0);
                chk("idle_gap", 32'(saw_idle), 1);
                saw_idle = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req wr=%0b addr=0x%0h", wr_req, wr_req ? wr_addr : rd_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("burst_dir", 32'(wr_req), 32'(mon_e.is_wr));
                    chk("burst_addr", 32'(wr_req ? wr_addr : rd_addr), 32'(mon_e.addr));
                    chk("burst_len", 32'(wr_req ? wr_length : rd_length), 32'(mon_e.len));
                end
                burst_cnt++;
            end
            wp = wr_req;
            rp = rd_req;
        end
    end

    // SDRAM responders: 8 ack cycles per accepted request.
    initial begin
        wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_req && !wr_noack) begin
                wr_ack = 1'b1;
                repeat (8) @(posedge clk);
                #1 wr_ack = 1'b0;
            end
        end
    end

    initial begin
        rd_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_req) begin
                rd_ack = 1'b1;
                repeat (8) @(posedge clk);
                #1 rd_ack = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0, r0;
        rst = 1'b1; init_end = 1'b0; rd_en = 1'b0; addr_reset = 1'b0;
        wr_lvl = 11'd0; rd_lvl = 11'd0;
        wr_base = 24'h1000; wr_end = 24'h100000; rd_base = 24'h2000; rd_end = 24'h3000;
        wr_len = 10'd0; rd_len = 10'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_wrap", 32'(wr_wrap | rd_wrap), 0);

        // init_end gating and request latency
        wr_lvl = 11'd512; wr_len = 10'd256;
        repeat (10) @(negedge clk);
        chk("noinit_busy", 32'(busy), 0);
        chk("noinit_wr_req", 32'(wr_req), 0);
        @(posedge clk);
        #1 init_end = 1'b1;
        push(1'b1, 24'h1000, 10'd256);
        @(posedge clk);
        #1 chk("init_req_early", 32'(wr_req), 0);
        @(posedge clk);
        #1 chk("init_req_2cyc", 32'(wr_req), 1);
        wr_lvl = 11'd0;
        wait_bursts(1, "t1_burst");
        wait_idle("t1_idle");

        // round-robin from reset: WR first
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        wr_len = 10'd8; rd_len = 10'd8;
        push(1'b1, 24'h1000, 10'd8); push(1'b0, 24'h2000, 10'd8);
        push(1'b1, 24'h1008, 10'd8); push(1'b0, 24'h2008, 10'd8);
        wr_lvl = 11'd100; rd_en = 1'b1;
        wait_bursts(5, "rr_bursts");
        wr_lvl = 11'd0; rd_en = 1'b0;
        wait_idle("rr_idle");

        // write pointer wrap
        wr_base = 24'h0; wr_end = 24'h300; wr_len = 10'h100;
        addr_reset = 1'b1;
        @(negedge clk) addr_reset = 1'b0;
        w0 = wr_wraps;
        push(1'b1, 24'h0, 10'h100); push(1'b1, 24'h100, 10'h100);
        push(1'b1, 24'h200, 10'h100); push(1'b1, 24'h0, 10'h100);
        wr_lvl = 11'd300;
        wait_bursts(9, "wrap_bursts");
        chk("wrap_before_4th", 32'(wr_wraps - w0), 1);
        wr_lvl = 11'd0;
        wait_idle("wrap_idle");
        chk("wrap_total", 32'(wr_wraps - w0), 1);

        // ack timeout, then retry at the same address
        wr_noack = 1'b1;
        push(1'b1, 24'h100, 10'h100);
        wr_lvl = 11'd300;
        n = 0;
        while (!wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        wr_lvl = 11'd0;
        n = 0;
        while (wr_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(n), TMO);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_err", 32'(err), 1);
        wr_noack = 1'b0;
        push(1'b1, 24'h100, 10'h100);
        wr_lvl = 11'd300;
        wait_bursts(11, "tmo_retry");
        wr_lvl = 11'd0;
        wait_idle("tmo_idle");
        chk("err_sticky", 32'(err), 1);

        // addr_reset pending during a read burst at 0x40
        rd_base = 24'h0; rd_end = 24'h1000; rd_len = 10'h20; rd_lvl = 11'd0;
        addr_reset = 1'b1;
        @(negedge clk) addr_reset = 1'b0;
        r0 = rd_wraps;
        push(1'b0, 24'h0, 10'h20); push(1'b0, 24'h20, 10'h20);
        push(1'b0, 24'h40, 10'h20); push(1'b0, 24'h0, 10'h20);
        rd_en = 1'b1;
        wait_bursts(14, "ar_third");
        addr_reset = 1'b1;
        @(negedge clk) addr_reset = 1'b0;
        wait_bursts(15, "ar_fourth");
        rd_en = 1'b0;
        wait_idle("ar_idle");
        chk("ar_no_rd_wrap", 32'(rd_wraps - r0), 0);

        // reset in the middle of a write burst
        push(1'b1, 24'h0, 10'h100);
        wr_lvl = 11'd300;
        wait_bursts(16, "rst_burst_start");
        repeat (3) @(negedge clk);
        rst = 1'b1; wr_lvl = 11'd0; wr_base = 24'h80;
        @(posedge clk);
        #1;
        chk("midrst_wr_req", 32'(wr_req), 0);
        chk("midrst_rd_req", 32'(rd_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err), 0);
        @(negedge clk) rst = 1'b0;
        repeat (12) @(negedge clk);
        push(1'b1, 24'h80, 10'h100);
        wr_lvl = 11'd300;
        wait_bursts(17, "midrst_base");
        wr_lvl = 11'd0;
        wait_idle("midrst_idle");

        // read FIFO space boundary
        rd_en = 1'b1; rd_len = 10'd32; rd_lvl = 11'd1000;
        repeat (10) @(negedge clk);
        chk("rdfull_busy", 32'(busy), 0);
        chk("rdfull_rd_req", 32'(rd_req), 0);
        push(1'b0, 24'h0, 10'd32);
        rd_lvl = 11'd992;
        wait_bursts(18, "rdspace_burst");
        rd_en = 1'b0;
        wait_idle("rdspace_idle");

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
